// File: rtl/useq_pkg.sv
// useq_pkg - shared definitions for the microprogram sequencer.
//   Geometry constants (address/word/strobe widths, start address, watchdog
//   limit), microword field positions, FSM state encoding and helpers that
//   split a microword into its strobe and target fields.
package useq_pkg;

  localparam int ADDR_W   = 4;
  localparam int WORD_W   = 7;
  localparam int STRB_W   = 3;
  localparam int WDOG_MAX = 31;
  localparam int WDOG_W   = $clog2(WDOG_MAX + 1);

  localparam logic [ADDR_W-1:0] START_A   = '0;
  localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(WDOG_MAX);

  localparam int STRB_LSB = 0;
  localparam int STRB_MSB = STRB_W - 1;
  localparam int TGT_LSB  = STRB_W;
  localparam int TGT_MSB  = WORD_W - 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_EXEC  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  function automatic logic [ADDR_W-1:0] word_tgt(input logic [WORD_W-1:0] w);
    return w[TGT_MSB:TGT_LSB];
  endfunction

  function automatic logic [STRB_W-1:0] word_strb(input logic [WORD_W-1:0] w);
    return w[STRB_MSB:STRB_LSB];
  endfunction

endpackage

// File: rtl/useq_next.sv
// useq_next - next micro-address and end-of-program decision.
//   upc      in   ADDR_W  current micro-PC
//   tgt      in   ADDR_W  branch target field of the current microword
//   cond     in   1       branch condition
//   next_upc out  ADDR_W  address of the next microword
//   last     out  1       current word ends the program (no branch, upc all-ones)
// A zero target means "no branch", so address 0 can never be a branch target.
module useq_next
  import useq_pkg::*;
(
  input  logic [ADDR_W-1:0] upc,
  input  logic [ADDR_W-1:0] tgt,
  input  logic              cond,
  output logic [ADDR_W-1:0] next_upc,
  output logic              last
);

  logic taken;

  assign taken    = (tgt != '0) && cond;
  assign next_upc = taken ? tgt : upc + ADDR_W'(1);
  // A taken branch from the top address wins over termination.
  assign last     = !taken && (upc == '1);

endmodule

// File: rtl/useq_ctrl.sv
// useq_ctrl - microprogram sequencer in front of the 16x7 micro-ROM.
//   clk      in   1       system clock, rising edge
//   rst      in   1       asynchronous active-high reset
//   start_i  in   1       run request, sampled in IDLE only
//   cond_i   in   1       branch condition, sampled in EXEC
//   stall_i  in   1       freezes EXEC while high
//   rom_a_o  out  ADDR_W  micro-address (always the micro-PC)
//   rom_d_i  in   WORD_W  microword from the combinational ROM
//   strb_o   out  STRB_W  control strobes, only in a non-stalled EXEC cycle
//   upc_o    out  ADDR_W  micro-PC, debug view
//   busy_o   out  1       high in FETCH and EXEC
//   done_o   out  1       one-cycle pulse on normal completion
//   err_o    out  1       one-cycle pulse on watchdog abort
// Build option: define USEQ_WATCHDOG_EN to bound each run to WDOG_MAX
// executed microwords; without it err_o is tied low and a loop runs forever.
//
// state | meaning
// IDLE  | waiting for start_i
// FETCH | ROM addressed by upc, microword captured into mir
// EXEC  | strobes out, next address chosen (holds while stall_i)
// DONE  | completion pulse, upc back to START_A
module useq_ctrl
  import useq_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic              cond_i,
  input  logic              stall_i,
  output logic [ADDR_W-1:0] rom_a_o,
  input  logic [WORD_W-1:0] rom_d_i,
  output logic [STRB_W-1:0] strb_o,
  output logic [ADDR_W-1:0] upc_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o
);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] upc, upc_nxt;
  logic [WORD_W-1:0] mir, mir_nxt;
  logic [ADDR_W-1:0] seq_upc;
  logic              seq_last;
  logic              wd_trip;
  logic              aborted;

  useq_next u_next (
    .upc      (upc),
    .tgt      (word_tgt(mir)),
    .cond     (cond_i),
    .next_upc (seq_upc),
    .last     (seq_last)
  );

`ifdef USEQ_WATCHDOG_EN
  logic [WDOG_W-1:0] step;

  // step counts executed words; the word that would exceed the limit trips.
  assign wd_trip = (step == WDOG_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      step    <= '0;
      aborted <= 1'b0;
    end else if (state == ST_IDLE && start_i) begin
      step    <= '0;
      aborted <= 1'b0;
    end else if (state == ST_EXEC && !stall_i) begin
      if (wd_trip) aborted <= 1'b1;
      else         step    <= step + WDOG_W'(1);
    end
  end
`else
  assign wd_trip = 1'b0;
  assign aborted = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      upc   <= START_A;
      mir   <= '0;
    end else begin
      state <= state_nxt;
      upc   <= upc_nxt;
      mir   <= mir_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    upc_nxt   = upc;
    mir_nxt   = mir;
    strb_o    = '0;
    done_o    = 1'b0;
    err_o     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start_i) begin
          upc_nxt   = START_A;
          state_nxt = ST_FETCH;
        end
      end
      ST_FETCH: begin
        mir_nxt   = rom_d_i;
        state_nxt = ST_EXEC;
      end
      ST_EXEC: begin
        if (!stall_i) begin
          if (wd_trip) begin
            // Aborted word: strobes stay low, upc is left where it stopped.
            state_nxt = ST_DONE;
          end else begin
            strb_o = word_strb(mir);
            if (seq_last) begin
              state_nxt = ST_DONE;
            end else begin
              upc_nxt   = seq_upc;
              state_nxt = ST_FETCH;
            end
          end
        end
      end
      ST_DONE: begin
        done_o    = !aborted;
        err_o     = aborted;
        upc_nxt   = START_A;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign busy_o  = (state == ST_FETCH) || (state == ST_EXEC);
  assign rom_a_o = upc;
  assign upc_o   = upc;

endmodule

// File: tb/tb_useq_ctrl.sv
module tb_useq_ctrl;
  import useq_pkg::*;

  logic              clk = 1'b0;
  logic              rst;
  logic              start_i, cond_i, stall_i;
  logic [ADDR_W-1:0] rom_a_o, upc_o;
  logic [WORD_W-1:0] rom_d_i;
  logic [STRB_W-1:0] strb_o;
  logic              busy_o, done_o, err_o;

  logic [WORD_W-1:0] rom [16];
  assign rom_d_i = rom[rom_a_o];

  always #5 clk = ~clk;

  useq_ctrl dut (
    .clk     (clk),
    .rst     (rst),
    .start_i (start_i),
    .cond_i  (cond_i),
    .stall_i (stall_i),
    .rom_a_o (rom_a_o),
    .rom_d_i (rom_d_i),
    .strb_o  (strb_o),
    .upc_o   (upc_o),
    .busy_o  (busy_o),
    .done_o  (done_o),
    .err_o   (err_o)
  );

  int errors = 0;
  int checks = 0;
  int trc[$];
  int st_upc[$];
  int st_strb[$];

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic fill(input logic [WORD_W-1:0] v);
    for (int i = 0; i < 16; i++) rom[i] = v;
  endtask

  function automatic int at(input int idx);
    return (idx < trc.size()) ? trc[idx] : -1;
  endfunction

  // Pulses (or holds) start, then watches cycle c = edges after the edge that
  // sampled start. Stops one cycle after done/err or after max_c cycles.
  task automatic run(input bit hold, input bit cnd, input int st_from, input int st_to,
                     input int max_c, output int done_at, output int err_at,
                     output int n_strb, output int bad, output int post_busy,
                     output int post_done);
    int fin;
    done_at = -1; err_at = -1; n_strb = 0; bad = 0;
    post_busy = -1; post_done = -1; fin = -1;
    trc.delete(); st_upc.delete(); st_strb.delete();
    @(negedge clk);
    start_i = 1'b1;
    cond_i  = cnd;
    stall_i = 1'b0;
    for (int c = 0; c <= max_c; c++) begin
      @(negedge clk);
      start_i = hold;
      cond_i  = cnd;
      stall_i = (c >= st_from) && (c <= st_to);
      #1;
      if (fin >= 0) begin
        post_busy = int'(busy_o);
        post_done = int'(done_o | err_o);
        break;
      end
      if (strb_o != '0) begin
        n_strb++;
        trc.push_back(int'(upc_o));
        if (!busy_o) bad++;
      end
      if (stall_i) begin
        st_upc.push_back(int'(upc_o));
        st_strb.push_back(int'(strb_o));
      end
      if (done_o && done_at < 0) done_at = c;
      if (err_o && err_at < 0) err_at = c;
      if (done_o || err_o) fin = c;
    end
  endtask

  initial begin
    int d, e, n, b, pb, pd, d2, spur;

    rst = 1'b1; start_i = 1'b0; cond_i = 1'b0; stall_i = 1'b0;
    fill(7'h01);
    #12;
    chk("rst_upc",   int'(upc_o),   0);
    chk("rst_rom_a", int'(rom_a_o), 0);
    chk("rst_strb",  int'(strb_o),  0);
    chk("rst_busy",  int'(busy_o),  0);
    chk("rst_done",  int'(done_o),  0);
    chk("rst_err",   int'(err_o),   0);
    @(negedge clk);
    rst = 1'b0;

    // Linear program of 16 words
    run(1'b0, 1'b0, -1, -1, 60, d, e, n, b, pb, pd);
    chk("lin_done_at", d, 32);
    chk("lin_err_at",  e, -1);
    chk("lin_nstrb",   n, 16);
    chk("lin_bad",     b, 0);
    chk("lin_first",   at(0), 0);
    chk("lin_last",    at(15), 15);
    chk("lin_post_busy", pb, 0);
    chk("lin_post_done", pd, 0);

    // Branch taken at word 2 -> 5
    rom[2] = 7'h29;
    run(1'b0, 1'b1, -1, -1, 60, d, e, n, b, pb, pd);
    chk("br1_done_at", d, 28);
    chk("br1_nstrb",   n, 14);
    chk("br1_t2",      at(2), 2);
    chk("br1_t3",      at(3), 5);
    chk("br1_t4",      at(4), 6);

    // Same program, condition false
    run(1'b0, 1'b0, -1, -1, 60, d, e, n, b, pb, pd);
    chk("br0_done_at", d, 32);
    chk("br0_t3",      at(3), 3);

    // Stall three cycles in EXEC of word 4
    fill(7'h01);
    run(1'b0, 1'b0, 9, 11, 60, d, e, n, b, pb, pd);
    chk("stl_done_at", d, 35);
    chk("stl_nstrb",   n, 16);
    chk("stl_len",     st_upc.size(), 3);
    for (int i = 0; i < st_upc.size(); i++) begin
      chk("stl_upc",  st_upc[i], 4);
      chk("stl_strb", st_strb[i], 0);
    end
    chk("stl_t4", at(4), 4);
    chk("stl_t5", at(5), 5);

    // Tight loop on word 3
    rom[3] = 7'h1D;
`ifdef USEQ_WATCHDOG_EN
    run(1'b0, 1'b1, -1, -1, 120, d, e, n, b, pb, pd);
    chk("wd_err_at",  e, 64);
    chk("wd_done_at", d, -1);
    chk("wd_nstrb",   n, 31);
    chk("wd_t30",     at(30), 3);
    chk("wd_post_busy", pb, 0);
`else
    run(1'b0, 1'b1, -1, -1, 100, d, e, n, b, pb, pd);
    chk("loop_done_at", d, -1);
    chk("loop_err_at",  e, -1);
    chk("loop_busy",    int'(busy_o), 1);
`endif
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;

    // Asynchronous reset in EXEC of word 7
    fill(7'h01);
    run(1'b0, 1'b0, -1, -1, 15, d, e, n, b, pb, pd);
    chk("mid_upc",  int'(upc_o),  7);
    chk("mid_strb", int'(strb_o), 1);
    #1 rst = 1'b1;
    #1;
    chk("ar_upc",   int'(upc_o),   0);
    chk("ar_rom_a", int'(rom_a_o), 0);
    chk("ar_strb",  int'(strb_o),  0);
    chk("ar_busy",  int'(busy_o),  0);
    chk("ar_done",  int'(done_o),  0);
    chk("ar_err",   int'(err_o),   0);
    @(negedge clk);
    rst = 1'b0;
    spur = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1;
      if (done_o || err_o || busy_o) spur++;
    end
    chk("ar_quiet", spur, 0);
    run(1'b0, 1'b0, -1, -1, 60, d, e, n, b, pb, pd);
    chk("ar_rerun_first",   at(0), 0);
    chk("ar_rerun_done_at", d, 32);

    // start_i held high: one run per IDLE visit
    run(1'b1, 1'b0, -1, -1, 60, d, e, n, b, pb, pd);
    chk("hold_done_at",   d, 32);
    chk("hold_nstrb",     n, 16);
    chk("hold_idle_busy", pb, 0);
    @(negedge clk);
    #1;
    chk("hold_restart_busy", int'(busy_o), 1);
    start_i = 1'b0;
    d2 = -1;
    for (int k = 35; k <= 80; k++) begin
      @(negedge clk);
      #1;
      if (done_o) begin
        d2 = k;
        break;
      end
    end
    chk("hold_second_done", d2, 66);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
